// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Finds the highest-power bin (I^2+Q^2) of each FFT frame streamed in one
//   bin per i_vld cycle and presents its index/power on a valid/ready
//   output. Bins are tagged with their index on entry, squared (S1), summed
//   (S2), staged (S3) and then folded into a running maximum; the result is
//   latched when the last bin of a frame has been folded in.
//
// Ports
//   clk              rising-edge clock
//   i_init_n         synchronous active-low reset
//   i_vld            a bin is presented this cycle
//   i_new_fft        with i_vld: this bin is bin 0 of a frame
//   i_I, i_Q         signed bin value
//   i_clip_strb      upstream clip strobe, accumulated per frame
//   i_rdy            downstream accepts the result
//   o_vld            result valid, held until accepted
//   o_peak_idx       bin index of the frame maximum
//   o_peak_pwr       I^2+Q^2 of that bin
//   o_clipped        a clip strobe was seen during the frame
//   o_drop_strb      pulse: a completed result was discarded (output busy)
//   o_frame_err_strb pulse: a frame was cut short by a new i_new_fft
module fft_peak_detect #(
  parameter  int IN_W    = 28,
  parameter  int FFT_LEN = 256,
  localparam int IDX_W   = $clog2(FFT_LEN),
  localparam int PWR_W   = 2*IN_W
) (
  input  logic                    clk,
  input  logic                    i_init_n,
  input  logic                    i_vld,
  input  logic                    i_new_fft,
  input  logic signed [IN_W-1:0]  i_I,
  input  logic signed [IN_W-1:0]  i_Q,
  input  logic                    i_clip_strb,
  input  logic                    i_rdy,
  output logic                    o_vld,
  output logic [IDX_W-1:0]        o_peak_idx,
  output logic [PWR_W-1:0]        o_peak_pwr,
  output logic                    o_clipped,
  output logic                    o_drop_strb,
  output logic                    o_frame_err_strb
);

  localparam int STAGES = 3;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FFT_LEN-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;

  // entry tag for the bin presented this cycle
  logic             tag_vld, tag_first, tag_err;
  logic [IDX_W-1:0] tag_idx;

  // side-band carried alongside the data through S1..S3
  logic [STAGES:1]            vld_pipe, first_pipe, err_pipe;
  logic [STAGES:1][IDX_W-1:0] idx_pipe;

  logic signed [PWR_W-2:0] i_ext, q_ext;
  logic [PWR_W-2:0]        sq_i, sq_q, s1_ii, s1_qq;
  logic [PWR_W-1:0]        s2_pwr, s3_pwr;

  logic [PWR_W-1:0] best, best_n;
  logic [IDX_W-1:0] best_idx, best_idx_n;
  logic             clip, clip_n, done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!i_init_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tag_vld   = 1'b0;
    tag_first = 1'b0;
    tag_err   = 1'b0;
    tag_idx   = cnt;
    if (i_vld) begin
      if (i_new_fft) begin
        // bin 0 always (re)starts a frame; mid-frame it flags the truncation
        tag_vld   = 1'b1;
        tag_first = 1'b1;
        tag_err   = (state == RUN) && (cnt != '0);
        tag_idx   = '0;
        state_n   = RUN;
        cnt_n     = IDX_W'(1);
      end else if (state == RUN) begin
        tag_vld = 1'b1;
        cnt_n   = cnt + 1'b1;
        if (cnt == LAST) state_n = IDLE;
      end
    end
  end

  // ----------------------------------------------------------- datapath
  // Squares of a signed value are non-negative and fit in PWR_W-1 bits,
  // including the (-2^(IN_W-1))^2 corner, so the low PWR_W-1 bits of the
  // sign-extended product are exact.
  assign i_ext = (PWR_W-1)'(i_I);
  assign q_ext = (PWR_W-1)'(i_Q);
  assign sq_i  = $unsigned(i_ext * i_ext);
  assign sq_q  = $unsigned(q_ext * q_ext);

  always_ff @(posedge clk) begin
    if (!i_init_n) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      err_pipe   <= '0;
      idx_pipe   <= '0;
      s1_ii      <= '0;
      s1_qq      <= '0;
      s2_pwr     <= '0;
      s3_pwr     <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], tag_vld};
      first_pipe <= {first_pipe[STAGES-1:1], tag_first};
      err_pipe   <= {err_pipe[STAGES-1:1], tag_err};
      idx_pipe   <= {idx_pipe[STAGES-1:1], tag_idx};
      s1_ii      <= sq_i;
      s1_qq      <= sq_q;
      s2_pwr     <= {1'b0, s1_ii} + {1'b0, s1_qq};
      s3_pwr     <= s2_pwr;
    end
  end

  // ------------------------------------------------------ peak tracking
  always_comb begin
    best_n     = best;
    best_idx_n = best_idx;
    clip_n     = clip | ((state == RUN) && i_clip_strb);
    if (vld_pipe[STAGES]) begin
      if (first_pipe[STAGES]) begin
        best_n     = s3_pwr;
        best_idx_n = '0;
        clip_n     = (state == RUN) && i_clip_strb;
      end else if (s3_pwr > best) begin
        // strict compare: the earliest bin keeps a tie
        best_n     = s3_pwr;
        best_idx_n = idx_pipe[STAGES];
      end
    end
  end

  assign done = vld_pipe[STAGES] && (idx_pipe[STAGES] == LAST);

  always_ff @(posedge clk) begin
    if (!i_init_n) begin
      best             <= '0;
      best_idx         <= '0;
      clip             <= 1'b0;
      o_vld            <= 1'b0;
      o_peak_idx       <= '0;
      o_peak_pwr       <= '0;
      o_clipped        <= 1'b0;
      o_drop_strb      <= 1'b0;
      o_frame_err_strb <= 1'b0;
    end else begin
      best             <= best_n;
      best_idx         <= best_idx_n;
      clip             <= clip_n;
      o_drop_strb      <= 1'b0;
      o_frame_err_strb <= vld_pipe[STAGES] && err_pipe[STAGES];
      if (done) begin
        if (!o_vld || i_rdy) begin
          // slot free, or being emptied this same edge
          o_vld      <= 1'b1;
          o_peak_idx <= best_idx_n;
          o_peak_pwr <= best_n;
          o_clipped  <= clip_n;
        end else begin
          o_drop_strb <= 1'b1;
        end
      end else if (i_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule
